// File: rtl/serial_alu_sequencer_if.sv
// ============================================================================
// Module      : serial_alu_sequencer_if
// Description : Request/response handshake bundle for the bit-serial ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_alu_sequencer_if #(
   parameter int WIDTH = 64
);
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             overflow;
   logic             zero;
   logic             negative;
   logic             done_valid;
   logic             done_ready;

   modport master (
      output start_valid, a, b, sub, done_ready,
      input  start_ready, result, carry, overflow, zero, negative, done_valid
   );

   modport slave (
      input  start_valid, a, b, sub, done_ready,
      output start_ready, result, carry, overflow, zero, negative, done_valid
   );
endinterface

`default_nettype wire

// File: rtl/serial_alu_sequencer.sv
// ============================================================================
// Module      : serial_alu_sequencer
// Description : Bit-serial add/subtract built around one shared full adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);
   assign sum   = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_alu_sequencer #(
   parameter int WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset_n,
   serial_alu_sequencer_if.slave bus
);
   localparam int                 c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_a_shift;
   logic [WIDTH-1:0]   r_b_shift;
   logic [WIDTH-1:0]   r_res_shift;
   logic               r_cy;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_start_ready;
   logic               r_done_valid;
   logic [WIDTH-1:0]   r_result;
   logic               r_carry;
   logic               r_overflow;
   logic               r_zero;
   logic               r_negative;

   logic               w_sum;
   logic               w_c_out;
   logic [WIDTH-1:0]   w_res_next;

   full_adder u_fa (
      .a     (r_a_shift[0]),
      .b     (r_b_shift[0]),
      .c_in  (r_cy),
      .sum   (w_sum),
      .c_out (w_c_out)
   );

   // Sum enters at the MSB so the word is LSB-aligned after WIDTH shifts.
   assign w_res_next = {w_sum, r_res_shift[WIDTH-1:1]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_a_shift     <= '0;
         r_b_shift     <= '0;
         r_res_shift   <= '0;
         r_cy          <= 1'b0;
         r_cnt         <= '0;
         r_start_ready <= 1'b0;
         r_done_valid  <= 1'b0;
         r_result      <= '0;
         r_carry       <= 1'b0;
         r_overflow    <= 1'b0;
         r_zero        <= 1'b0;
         r_negative    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_start_ready <= 1'b1;
               if (bus.start_valid && r_start_ready) begin
                  // Subtraction is A + ~B + 1: invert B here, seed carry with 1.
                  r_a_shift     <= bus.a;
                  r_b_shift     <= bus.b ^ {WIDTH{bus.sub}};
                  r_cy          <= bus.sub;
                  r_cnt         <= '0;
                  r_start_ready <= 1'b0;
                  r_state       <= S_RUN;
               end
            end

            S_RUN: begin
               r_res_shift <= w_res_next;
               r_a_shift   <= {1'b0, r_a_shift[WIDTH-1:1]};
               r_b_shift   <= {1'b0, r_b_shift[WIDTH-1:1]};
               r_cy        <= w_c_out;
               r_cnt       <= r_cnt + 1'b1;
               if (r_cnt == c_LAST) begin
                  // r_cy is still the carry into the MSB on this cycle.
                  r_result     <= w_res_next;
                  r_carry      <= w_c_out;
                  r_overflow   <= r_cy ^ w_c_out;
                  r_zero       <= (w_res_next == '0);
                  r_negative   <= w_sum;
                  r_done_valid <= 1'b1;
                  r_state      <= S_DONE;
               end
            end

            S_DONE: begin
               if (bus.done_ready) begin
                  r_done_valid  <= 1'b0;
                  r_start_ready <= 1'b1;
                  r_state       <= S_IDLE;
               end
            end

            default: begin
               r_done_valid  <= 1'b0;
               r_start_ready <= 1'b0;
               r_state       <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.start_ready = r_start_ready;
   assign bus.done_valid  = r_done_valid;
   assign bus.result      = r_result;
   assign bus.carry       = r_carry;
   assign bus.overflow    = r_overflow;
   assign bus.zero        = r_zero;
   assign bus.negative    = r_negative;

endmodule

`default_nettype wire

// File: tb/tb_serial_alu_sequencer.sv
// ============================================================================
// Module      : tb_serial_alu_sequencer
// Description : Directed and randomized bench for the bit-serial ALU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_alu_sequencer;
   localparam int WIDTH  = 64;
   localparam int c_TMO  = 300;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   n_vec   = 0;
   int   n_err   = 0;

   logic [WIDTH-1:0] exp_res;
   logic             exp_cy, exp_ov, exp_z, exp_n;

   serial_alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

   serial_alu_sequencer #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #50 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: two's-complement arithmetic on a widened word.
   task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic ms);
      logic [WIDTH:0] full;
      logic [WIDTH-1:0] opb;
      opb  = ms ? ~mb : mb;
      full = {1'b0, ma} + {1'b0, opb} + {{WIDTH{1'b0}}, ms};
      exp_res = full[WIDTH-1:0];
      exp_cy  = full[WIDTH];
      if (ms) exp_ov = (ma[WIDTH-1] != mb[WIDTH-1]) && (exp_res[WIDTH-1] != ma[WIDTH-1]);
      else    exp_ov = (ma[WIDTH-1] == mb[WIDTH-1]) && (exp_res[WIDTH-1] != ma[WIDTH-1]);
      exp_z = (exp_res == '0);
      exp_n = exp_res[WIDTH-1];
   endtask

   task automatic check_result();
      chk("result",   bus.result,   exp_res);
      chk("carry",    bus.carry,    exp_cy);
      chk("overflow", bus.overflow, exp_ov);
      chk("zero",     bus.zero,     exp_z);
      chk("negative", bus.negative, exp_n);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.start_ready && n < c_TMO) begin
         tick();
         n++;
      end
      if (n >= c_TMO) chk("ready_timeout", 0, 1);
   endtask

   task automatic wait_done();
      int lat = 0;
      while (!bus.done_valid && lat < c_TMO) begin
         tick();
         lat++;
      end
      chk("latency", lat, WIDTH);
      chk("ready_in_done", bus.start_ready, 0);
   endtask

   task automatic handshake();
      bus.done_ready = 1'b1;
      tick();
      bus.done_ready = 1'b0;
      chk("done_cleared", bus.done_valid, 0);
      chk("ready_after_done", bus.start_ready, 1);
   endtask

   task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic ts, input int hold);
      wait_ready();
      bus.a = ta; bus.b = tb; bus.sub = ts; bus.start_valid = 1'b1;
      tick();
      bus.start_valid = 1'b0;
      chk("accept", bus.start_ready, 0);
      model(ta, tb, ts);
      wait_done();
      check_result();
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_valid", bus.done_valid, 1);
         chk("hold_result", bus.result, exp_res);
      end
      handshake();
   endtask

   function automatic logic [WIDTH-1:0] pick_operand();
      logic [WIDTH-1:0] v;
      case ($urandom_range(0, 5))
         0:       v = '0;
         1:       v = '1;
         2:       v = {1'b1, {(WIDTH-1){1'b0}}};
         3:       v = {1'b0, {(WIDTH-1){1'b1}}};
         4:       v = WIDTH'($urandom_range(0, 15));
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   initial begin
      int seen;
      logic [WIDTH-1:0] r_snap;

      bus.start_valid = 1'b0;
      bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.done_ready = 1'b0;

      // Reset held for three cycles.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_result", bus.result, 0);
         chk("rst_flags", {bus.carry, bus.overflow, bus.zero, bus.negative}, 0);
         chk("rst_handshake", {bus.start_ready, bus.done_valid}, 0);
      end
      reset_n = 1'b1;
      chk("ready_pre_edge", bus.start_ready, 0);
      tick();
      chk("ready_post_edge", bus.start_ready, 1);
      chk("done_post_rst", bus.done_valid, 0);

      // Directed cases.
      do_op(64'd5, 64'd3, 1'b0, 0);
      do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
      do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
      do_op(64'd5, 64'd5, 1'b1, 0);

      // Backpressure with a request held throughout.
      wait_ready();
      bus.a = 64'h0123_4567_89AB_CDEF; bus.b = 64'h1111_1111_1111_1111;
      bus.sub = 1'b0; bus.start_valid = 1'b1;
      tick();
      chk("bp_accept", bus.start_ready, 0);
      model(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
      bus.a = 64'h10; bus.b = 64'h20;
      wait_done();
      check_result();
      r_snap = bus.result;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_valid", bus.done_valid, 1);
         chk("bp_ready", bus.start_ready, 0);
         chk("bp_result", bus.result, r_snap);
      end
      check_result();
      handshake();
      tick();
      chk("bp_pending_accept", bus.start_ready, 0);
      bus.start_valid = 1'b0;
      model(64'h10, 64'h20, 1'b0);
      wait_done();
      check_result();
      handshake();

      // Reset while bit 30 is in flight.
      wait_ready();
      bus.a = 64'h1234_5678_9ABC_DEF0; bus.b = 64'h0F0F_0F0F_0F0F_0F0F;
      bus.sub = 1'b0; bus.start_valid = 1'b1;
      tick();
      bus.start_valid = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      #20;
      reset_n = 1'b0;
      #1;
      chk("abort_result", bus.result, 0);
      chk("abort_flags", {bus.carry, bus.overflow, bus.zero, bus.negative}, 0);
      chk("abort_handshake", {bus.start_ready, bus.done_valid}, 0);
      tick();
      tick();
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (bus.done_valid) seen++;
      end
      chk("abort_no_done", seen, 0);
      do_op(64'd1, 64'd2, 1'b0, 0);

      // Randomized operations.
      for (int n = 0; n < 30; n++) begin
         logic [WIDTH-1:0] ra, rb;
         ra = pick_operand();
         rb = pick_operand();
         do_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/serial_alu_sequencer.md
# serial_alu_sequencer

Bit-serial add/subtract sequencer that time-shares a single 1-bit `full_adder` instance across all operand bits. It accepts a WIDTH-bit operand pair and an operation select through a valid/ready handshake, then walks the adder LSB-first, one bit per clock. It presents the result and ALU flags on a held output handshake. It is the low-area alternative to the parallel ripple adder in the 64-bit ALU datapath.

## Interface
Parameters:
- `WIDTH`, 64: operand/result width; legal range 2..64.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset. Assertion takes effect immediately; release is synchronous to `clk`.
- `start_valid` input 1: operation request.
- `start_ready` output 1: sequencer can accept a request.
- `a` input WIDTH: operand A, sampled on the accept edge.
- `b` input WIDTH: operand B, sampled on the accept edge.
- `sub` input 1: 0 = A+B, 1 = A−B; sampled on the accept edge.
- `result` output WIDTH: sum or difference.
- `carry` output 1: carry out of the MSB. For subtraction, 1 = no borrow.
- `overflow` output 1: signed overflow.
- `zero` output 1: `result` == 0.
- `negative` output 1: `result[WIDTH-1]`.
- `done_valid` output 1: result and flags are valid.
- `done_ready` input 1: consumer accepts the result.

## Operation
- The block contains exactly one `full_adder` instance. No other adder logic is permitted.
- FSM states:
  - IDLE
    - `start_ready`=1.
    - On `start_valid`&&`start_ready`: latch A, B^{WIDTH{sub}}, and `sub`; carry register ← `sub`; bit counter ← 0; go to RUN.
  - RUN
    - Each cycle, the adder takes A-shift[0], B-shift[0], and the carry register.
    - `sum` shifts into the result register MSB-first so it is LSB-aligned after WIDTH shifts.
    - `c_out` → carry register. Both operand shift registers shift right.
    - Counter increments.
    - On the cycle processing bit WIDTH-1, capture the carry-in to the MSB for overflow.
    - On the edge that completes bit WIDTH-1, go to DONE.
  - DONE
    - `done_valid`=1.
    - `result`, `carry`, `overflow`, `zero`, and `negative` are stable.
    - On `done_valid`&&`done_ready`, go to IDLE.
- Flag rules:
  - `overflow` = carry-in to MSB XOR final carry.
  - `zero` and `negative` are computed from the final result register.
- `start_valid` is ignored outside IDLE. A request held during RUN/DONE is accepted only once back in IDLE.
- Outputs hold their last values after leaving DONE until the next DONE.
- Reset (any state, including mid-RUN):
  - FSM → IDLE; the operation is aborted and no `done_valid` is produced.
  - `result`=0; all flags=0; `done_valid`=0; `start_ready`=0 while `reset_n` is low, 1 from the first edge after release.

## Timing
- Accept edge = T0. RUN occupies edges T1..TWIDTH.
- `done_valid` rises after edge TWIDTH: 64 cycles of latency from accept for WIDTH=64.
- Minimum issue interval is WIDTH+2 cycles: accept, WIDTH RUN cycles, one DONE cycle with immediate `done_ready`.
- `start_ready` and `done_valid` are never both 1.
- Combinational path through the adder is 3 gate levels (15 time units at 10 ps = 150 ps). The clock period must exceed this plus register setup. Benches use a 100-unit (1 ns) period.
- No combinational path from `start_valid` or `done_ready` to any output.

## Test plan
- Reset:
  - Stimulus: assert `reset_n`=0 for 3 cycles, then release.
  - Required: all outputs 0 during reset; `start_ready`=1 on the first edge after release; `done_valid` stays 0.
- Basic add:
  - Stimulus: a=5, b=3, sub=0.
  - Required: `result`=8, carry=0, overflow=0, zero=0, negative=0; `done_valid` rises exactly 64 cycles after the accept edge.
- Unsigned wrap:
  - Stimulus: a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0.
  - Required: `result`=0, carry=1, zero=1, overflow=0, negative=0.
- Signed overflow via subtract:
  - Stimulus 1: a=0x7FFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF, sub=1.
  - Required 1: `result`=0x8000_0000_0000_0000, overflow=1, negative=1, carry=0.
  - Stimulus 2: a=5, b=5, sub=1.
  - Required 2: `result`=0, zero=1, carry=1.
- Backpressure:
  - Stimulus: hold `done_ready`=0 for 10 cycles after `done_valid` rises, with `start_valid`=1 throughout.
  - Required: `result` and flags are unchanged, `start_ready`=0, no new accept.
  - Required: when `done_ready` goes to 1, IDLE follows on the next edge and the pending request is accepted one cycle later.
- Mid-operation reset:
  - Stimulus: pull `reset_n` low while processing bit 30.
  - Required: outputs go to 0 immediately; no `done_valid` ever appears for the aborted operation.
  - Required: a following a=1, b=2 add returns 3 with normal 64-cycle latency.
